l1_thresh_loader: RTL and testbench
===================================

# l1_thresh_loader

Sequencer that loads beamformer threshold and subthreshold values from a threshold RAM into the L1 beam-trigger threshold cascade. Two load requesters share one RAM read port: set 0 is the real thresholds and set 1 is the subthresholds. A round-robin arbiter picks which set to load. For the granted set, the block shifts all NBEAMS values into that set's cascade, then pulses that set's update strobe. The block sits between the threshold Wishbone register logic and the tclk beam-trigger datapath, and runs in the trigger-side clock domain.

## Interface
- NBEAMS, 2, number of beams, i.e. cascade depth per set; legal range ≥1.
- clk_i  in  1  sole clock; all logic is in this domain.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  2  load request, one bit per set (bit0 = thresholds, bit1 = subthresholds); level, held until ack.
- ack_o  out  2  one-cycle pulse per set, marking load complete; reset 0.
- ram_adr_o  out  1+$clog2(NBEAMS)  threshold RAM read address {set, beam}; reset 0.
- ram_dat_i  in  18  RAM read data; valid exactly 1 cycle after the address is presented.
- thresh_o  out  36  cascade data, 18 bits per set; reset 0.
- thresh_wr_o  out  2  cascade shift strobe per set; reset 0.
- thresh_update_o  out  2  cascade commit strobe per set; reset 0.
- busy_o  out  1  high from grant through the update cycle; reset 0.

## Operation
- States: IDLE, LOAD, UPDATE.
- **IDLE**
  - If req_i ≠ 0, grant one set (see arbitration), latch it as `gset`, clear the beam counter, and go to LOAD.
  - Otherwise stay in IDLE.
- **Arbitration**
  - A `last` pointer records the set served most recently; its reset value is 1, so set 0 wins the first tie.
  - When both requests are high, grant `!last`.
  - When only one request is high, grant that set.
  - Update `last` on every grant.
- **LOAD** (one address per cycle, pipelined)
  - Issue addresses {gset, NBEAMS-1-k} for k = 0..NBEAMS-1. The highest beam goes first, so beam 0 is written last and ends at the cascade head.
  - One cycle after each address, drive thresh_o[18*gset +: 18] = ram_dat_i, registered, and pulse thresh_wr_o[gset].
  - Hold the other set's slice of thresh_o at 0 and its strobes at 0.
  - After the NBEAMS-th write, go to UPDATE.
- **UPDATE**: for one cycle, assert thresh_update_o[gset] and ack_o[gset] together, then return to IDLE.
- **Request handling**
  - A request that drops mid-load is ignored; the load still completes and acks.
  - A request still high after its ack is treated as a new request and is re-arbitrated in IDLE.
- **Reset mid-operation**
  - Reset aborts the load and returns the block to IDLE in the next cycle.
  - No update or ack pulse is issued for the aborted load, so the committed thresholds are unchanged.
  - The partially shifted cascade is overwritten by the next full load.
- **Exclusivity**: the two sets' strobes are never asserted in the same cycle, and thresh_wr_o and thresh_update_o are never asserted in the same cycle.

## Timing
- Let cycle 0 be the IDLE cycle that samples a request.
- Cycle 1: first address, beam NBEAMS-1.
- Cycles 2..NBEAMS+1: thresh_wr_o pulses, one per cycle with no gaps, for beams NBEAMS-1 down to 0.
- Cycle NBEAMS+2: thresh_update_o and ack_o pulse.
- Cycle NBEAMS+3: back in IDLE; the earliest next grant is sampled here.
- Service time per load is NBEAMS+3 cycles.
- Worst-case wait for a continuously asserted request is 2·(NBEAMS+3) cycles.
- NBEAMS=1: a single write is issued in cycle 2 and the update in cycle 3.
- All outputs are registered; no combinational path runs from req_i or ram_dat_i to any output.

## Structure
- Shared package l1_trig_pkg holds:
  - THRESH_BITS = 18;
  - NSETS = 2;
  - the state enum (IDLE, LOAD, UPDATE);
  - set index constants SET_THRESH = 0 and SET_SUBTHRESH = 1.
- Sub-module rr_arb2 is a 2-way round-robin arbiter with inputs req, take and clk/rst, and outputs grant and last. It is reusable elsewhere.
- Implement the beam counter as a $clog2(NBEAMS)-bit down-counter.
- Implement the 1-cycle RAM latency as a registered valid/set pipeline stage.

## Test plan
- **Set 0 only**: NBEAMS=2, RAM {0,1}=0x00123 and {0,0}=0x00456; req_i=01.
  - Writes in cycles 2 and 3 carry 0x00123 then 0x00456 on thresh_o[17:0].
  - thresh_update_o=01 and ack_o=01 in cycle 4; thresh_o[35:18]=0.
- **Simultaneous requests**: req_i=11 out of reset.
  - Set 0 is loaded and acked first, then set 1 on thresh_o[35:18].
  - Total 10 cycles; the strobes never overlap.
- **Fairness**: req_i held at 11 for 4 loads → ack order 0,1,0,1.
- **Request drop**: raise req_i[1], drop it in cycle 2.
  - The load completes and ack_o[1] still pulses in cycle 4.
- **Reset mid-load**: assert rst_i in cycle 2.
  - thresh_update_o stays 0 and ack_o stays 0; all outputs are 0 and the block is in IDLE the next cycle.
  - A new request then gets a full load.
- **NBEAMS=4**: RAM set 1 holds 0x3FFFF, 0, 0x20000, 1.
  - Writes are issued in beam order 3,2,1,0 with those values, and the update occurs in cycle 6.

Source files
------------

// File: rtl/l1_trig_pkg.sv
// Shared L1 trigger definitions: threshold widths, set indices and the
// loader state enum used by the threshold cascade sequencer.
package l1_trig_pkg;

  localparam int THRESH_BITS   = 18;
  localparam int NSETS         = 2;
  localparam int SET_THRESH    = 0;
  localparam int SET_SUBTHRESH = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UPDATE = 2'd2
  } ldr_state_e;

  // One-hot strobe vector for a set index.
  function automatic logic [NSETS-1:0] set_onehot(input logic set);
    set_onehot      = '0;
    set_onehot[set] = 1'b1;
  endfunction

endpackage

// File: rtl/l1_thresh_loader_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// last-served pointer; the pointer advances only when the owner takes a grant.
module rr_arb2
  import l1_trig_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NSETS-1:0] req,
  input  logic             take,
  output logic [NSETS-1:0] grant,
  output logic             last
);

  // Serve a lone requester directly; on a tie favour the set not served last.
  always_comb begin
    grant = '0;
    if (req[SET_THRESH] && req[SET_SUBTHRESH]) begin
      if (last) begin
        grant[SET_THRESH] = 1'b1;
      end else begin
        grant[SET_SUBTHRESH] = 1'b1;
      end
    end else begin
      grant = req;
    end
  end

  // Record the served set; resetting to set 1 lets set 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (take && (|req)) begin
      last <= grant[SET_SUBTHRESH];
    end
  end

endmodule

// File: rtl/l1_thresh_loader.sv
// Threshold cascade loader: arbitrates between the threshold and
// subthreshold load requests, streams all NBEAMS RAM words of the granted
// set into its cascade (highest beam first) and then pulses the set's
// update and ack strobes. Every output is registered.
module l1_thresh_loader
  import l1_trig_pkg::*;
#(
  parameter int NBEAMS = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NSETS-1:0]               req_i,
  output logic [NSETS-1:0]               ack_o,
  output logic [$clog2(NBEAMS):0]        ram_adr_o,
  input  logic [THRESH_BITS-1:0]         ram_dat_i,
  output logic [NSETS*THRESH_BITS-1:0]   thresh_o,
  output logic [NSETS-1:0]               thresh_wr_o,
  output logic [NSETS-1:0]               thresh_update_o,
  output logic                           busy_o
);

  localparam int BEAM_W = $clog2(NBEAMS);
  localparam int CNT_W  = (BEAM_W > 0) ? BEAM_W : 1;
  localparam int ADR_W  = BEAM_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAM = CNT_W'(NBEAMS - 1);

  ldr_state_e state_q, state_d;

  logic                         take;
  logic [NSETS-1:0]             grant;
  logic                         gset;

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [ADR_W-1:0]             adr_d;
  logic                         adr_v_q, adr_v_d;
  logic                         adr_set_q, adr_set_d;
  logic                         wr_v_q;

  logic [NSETS*THRESH_BITS-1:0] thr_d;
  logic [NSETS-1:0]             wr_d;
  logic [NSETS-1:0]             upd_d;
  logic [NSETS-1:0]             ack_d;
  logic                         busy_d;

  // RAM address {set, beam} for the given set and beam number.
  function automatic logic [ADR_W-1:0] beam_adr(input logic set,
                                                input logic [CNT_W-1:0] beam);
    beam_adr = (ADR_W'(set) << BEAM_W) | ADR_W'(beam);
  endfunction

  // A grant is only taken while idle; the arbiter's pointer then holds the
  // granted set for the whole load, so it doubles as the latched set.
  assign take = (state_q == IDLE) && (|req_i);

  rr_arb2 u_arb (
    .clk   (clk_i),
    .rst   (rst_i),
    .req   (req_i),
    .take  (take),
    .grant (grant),
    .last  (gset)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave LOAD once the last address has drained and its write is out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = LOAD;
      LOAD:    if (!adr_v_q && wr_v_q) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the address stage, write stage and strobes.
  always_comb begin
    cnt_d     = cnt_q;
    adr_d     = ram_adr_o;
    adr_v_d   = 1'b0;
    adr_set_d = adr_set_q;
    thr_d     = '0;
    wr_d      = '0;
    upd_d     = '0;
    ack_d     = '0;
    busy_d    = (state_d != IDLE);

    unique case (state_q)
      IDLE: begin
        if (take) begin
          cnt_d     = LAST_BEAM;
          adr_d     = beam_adr(grant[SET_SUBTHRESH], LAST_BEAM);
          adr_v_d   = 1'b1;
          adr_set_d = grant[SET_SUBTHRESH];
        end
      end
      LOAD: begin
        if (adr_v_q && (cnt_q != '0)) begin
          cnt_d   = cnt_q - 1'b1;
          adr_d   = beam_adr(gset, cnt_q - 1'b1);
          adr_v_d = 1'b1;
        end
        if (state_d == UPDATE) begin
          upd_d = set_onehot(gset);
          ack_d = set_onehot(gset);
        end
      end
      default: ;
    endcase

    if (adr_v_q) begin
      wr_d = set_onehot(adr_set_q);
      thr_d[THRESH_BITS*int'(adr_set_q) +: THRESH_BITS] = ram_dat_i;
    end
  end

  // Register the address/valid stage, the RAM data stage and all outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q           <= '0;
      ram_adr_o       <= '0;
      adr_v_q         <= 1'b0;
      adr_set_q       <= 1'b0;
      wr_v_q          <= 1'b0;
      thresh_o        <= '0;
      thresh_wr_o     <= '0;
      thresh_update_o <= '0;
      ack_o           <= '0;
      busy_o          <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      ram_adr_o       <= adr_d;
      adr_v_q         <= adr_v_d;
      adr_set_q       <= adr_set_d;
      wr_v_q          <= adr_v_q;
      thresh_o        <= thr_d;
      thresh_wr_o     <= wr_d;
      thresh_update_o <= upd_d;
      ack_o           <= ack_d;
      busy_o          <= busy_d;
    end
  end

endmodule

// File: tb/tb_l1_thresh_loader.sv
// Testbench for l1_thresh_loader: an NBEAMS=2 and an NBEAMS=4 instance run
// side by side against a timeline model built from the load rules.
module tb_l1_thresh_loader;

  localparam int CYC = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_a, req_b;
  logic [1:0]  ack_a, ack_b, wr_a, wr_b, upd_a, upd_b;
  logic        busy_a, busy_b;
  logic [1:0]  adr_a;
  logic [2:0]  adr_b;
  logic [17:0] rd_a, rd_b;
  logic [35:0] thr_a, thr_b;

  logic [17:0] mem_a [4];
  logic [17:0] mem_b [8];

  // Read data tracks the address and is sampled by the DUT on the next edge.
  assign rd_a = mem_a[adr_a];
  assign rd_b = mem_b[adr_b];

  l1_thresh_loader #(.NBEAMS(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .ack_o(ack_a),
    .ram_adr_o(adr_a), .ram_dat_i(rd_a), .thresh_o(thr_a),
    .thresh_wr_o(wr_a), .thresh_update_o(upd_a), .busy_o(busy_a)
  );

  l1_thresh_loader #(.NBEAMS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .ack_o(ack_b),
    .ram_adr_o(adr_b), .ram_dat_i(rd_b), .thresh_o(thr_b),
    .thresh_wr_o(wr_b), .thresh_update_o(upd_b), .busy_o(busy_b)
  );

  int tests;
  int failed;
  int cyc;

  logic [35:0] e_thr    [2][CYC];
  logic [1:0]  e_wr     [2][CYC];
  logic [1:0]  e_upd    [2][CYC];
  logic [1:0]  e_ack    [2][CYC];
  logic        e_busy   [2][CYC];
  logic [3:0]  e_adr    [2][CYC];
  bit          e_adrchk [2][CYC];
  int          free_at  [2];
  bit          last_set [2];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
    end
  endtask

  // Plan the expected output timeline for instance i given this cycle's inputs.
  task automatic modelCycle(input int i, input bit r, input logic [1:0] q);
    int n;
    bit g;
    int a;
    logic [17:0] d;
    n = (i == 0) ? 2 : 4;
    if (r) begin
      for (int k = cyc + 1; k <= cyc + 8; k++) begin
        e_thr[i][k] = '0; e_wr[i][k] = '0; e_upd[i][k] = '0;
        e_ack[i][k] = '0; e_busy[i][k] = 1'b0; e_adrchk[i][k] = 1'b0;
      end
      e_adrchk[i][cyc+1] = 1'b1;
      e_adr[i][cyc+1]    = '0;
      free_at[i]         = cyc + 1;
      last_set[i]        = 1'b1;
    end else if (cyc >= free_at[i] && q != 2'b00) begin
      g = (q == 2'b11) ? !last_set[i] : q[1];
      last_set[i] = g;
      for (int k = 1; k <= n + 2; k++) e_busy[i][cyc+k] = 1'b1;
      for (int k = 0; k < n; k++) begin
        a = int'(g) * n + (n - 1 - k);
        if (i == 0) d = mem_a[a];
        else        d = mem_b[a];
        e_adr[i][cyc+1+k]    = 4'(a);
        e_adrchk[i][cyc+1+k] = 1'b1;
        e_wr[i][cyc+2+k]     = g ? 2'b10 : 2'b01;
        e_thr[i][cyc+2+k]    = g ? {d, 18'h0} : {18'h0, d};
      end
      e_upd[i][cyc+n+2] = g ? 2'b10 : 2'b01;
      e_ack[i][cyc+n+2] = g ? 2'b10 : 2'b01;
      free_at[i] = cyc + n + 3;
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [1:0] qa, input logic [1:0] qb);
    rst   = r;
    req_a = qa;
    req_b = qb;
    modelCycle(0, r, qa);
    modelCycle(1, r, qb);
  endtask

  task automatic checkOutput();
    chk("n2.ack",    36'(ack_a),  36'(e_ack[0][cyc]));
    chk("n2.wr",     36'(wr_a),   36'(e_wr[0][cyc]));
    chk("n2.thresh", thr_a,       e_thr[0][cyc]);
    chk("n2.update", 36'(upd_a),  36'(e_upd[0][cyc]));
    chk("n2.busy",   36'(busy_a), 36'(e_busy[0][cyc]));
    if (e_adrchk[0][cyc]) chk("n2.adr", 36'(adr_a), 36'(e_adr[0][cyc]));
    chk("n4.ack",    36'(ack_b),  36'(e_ack[1][cyc]));
    chk("n4.wr",     36'(wr_b),   36'(e_wr[1][cyc]));
    chk("n4.thresh", thr_b,       e_thr[1][cyc]);
    chk("n4.update", 36'(upd_b),  36'(e_upd[1][cyc]));
    chk("n4.busy",   36'(busy_b), 36'(e_busy[1][cyc]));
    if (e_adrchk[1][cyc]) chk("n4.adr", 36'(adr_b), 36'(e_adr[1][cyc]));
  endtask

  task automatic step(input bit r, input logic [1:0] qa, input logic [1:0] qb, input int n);
    for (int s = 0; s < n; s++) begin
      applyStimulus(r, qa, qb);
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    cyc    = 0;
    rst    = 1'b1;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < 2; i++) begin
      free_at[i]  = 0;
      last_set[i] = 1'b1;
      for (int k = 0; k < CYC; k++) begin
        e_thr[i][k] = '0; e_wr[i][k] = '0; e_upd[i][k] = '0; e_ack[i][k] = '0;
        e_busy[i][k] = 1'b0; e_adr[i][k] = '0; e_adrchk[i][k] = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) mem_a[k] = 18'h0;
    for (int k = 0; k < 8; k++) mem_b[k] = 18'h0;

    $display("[TB] reset");
    step(1'b1, 2'b00, 2'b00, 3);

    $display("[TB] set 0 only");
    mem_a[1] = 18'h00123;
    mem_a[0] = 18'h00456;
    mem_a[3] = 18'h2ABCD;
    mem_a[2] = 18'h15432;
    step(1'b0, 2'b01, 2'b00, 5);
    step(1'b0, 2'b00, 2'b00, 3);

    $display("[TB] simultaneous requests out of reset");
    step(1'b1, 2'b00, 2'b00, 2);
    step(1'b0, 2'b11, 2'b00, 10);
    step(1'b0, 2'b00, 2'b00, 3);

    $display("[TB] fairness");
    step(1'b0, 2'b11, 2'b00, 20);
    step(1'b0, 2'b00, 2'b00, 3);

    $display("[TB] request drop");
    step(1'b0, 2'b10, 2'b00, 2);
    step(1'b0, 2'b00, 2'b00, 6);

    $display("[TB] reset mid-load");
    step(1'b0, 2'b01, 2'b00, 2);
    step(1'b1, 2'b00, 2'b00, 1);
    step(1'b0, 2'b00, 2'b00, 2);
    step(1'b0, 2'b01, 2'b00, 5);
    step(1'b0, 2'b00, 2'b00, 3);

    $display("[TB] NBEAMS=4 subthreshold load");
    mem_b[7] = 18'h3FFFF;
    mem_b[6] = 18'h00000;
    mem_b[5] = 18'h20000;
    mem_b[4] = 18'h00001;
    mem_b[3] = 18'h0AAAA;
    mem_b[2] = 18'h05555;
    mem_b[1] = 18'h12345;
    mem_b[0] = 18'h3C3C3;
    step(1'b0, 2'b00, 2'b10, 7);
    step(1'b0, 2'b00, 2'b00, 3);

    $display("[TB] random traffic");
    for (int k = 0; k < 4; k++) mem_a[k] = 18'($urandom);
    for (int k = 0; k < 8; k++) mem_b[k] = 18'($urandom);
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), 2'($urandom), 2'($urandom), 1);
    end
    step(1'b0, 2'b00, 2'b00, 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
